flux_scheduler: RTL and testbench
=================================

FLUX_SCHEDULER -- requirements
Module: flux_scheduler

Interface
REQ-001 SHALL have parameter FLUX, default 2: number of independent data fluxes sharing one two-operand actor.
REQ-002 SHALL have parameter BURST, default 4: maximum consecutive transfers per grant (range 1..255).
REQ-003 SHALL derive TAG_WIDTH = max(1, $clog2(FLUX)).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  scheduler enable; 0 pauses all transfers.
REQ-007 flux_mask  input  FLUX  per-flux enable; bit i = 1 allows flux i.
REQ-008 empty_a  input  FLUX  operand-A FIFO empty, per flux.
REQ-009 empty_b  input  FLUX  operand-B FIFO empty, per flux.
REQ-010 full_sum  input  FLUX  result FIFO full, per flux.
REQ-011 read_a  output  FLUX  operand-A pop, one-hot or zero.
REQ-012 read_b  output  FLUX  operand-B pop, identical to read_a.
REQ-013 write_sum  output  1  result push.
REQ-014 tag  output  TAG_WIDTH  granted flux index, prepended by the actor to din.
REQ-015 busy  output  1  1 while in SERVE.
REQ-016 fire_cnt  output  16  total completed transfers, wrapping.

Function
REQ-017 elig[i] SHALL be flux_mask[i] & !empty_a[i] & !empty_b[i] & !full_sum[i], combinational.
REQ-018 SHALL implement the states IDLE and SERVE, with registers tag_q, ptr (search start) and burst_cnt.
REQ-019 fire SHALL be (state==SERVE) & en & elig[tag_q], combinational, with zero-cycle latency to the outputs.
REQ-020 read_a[tag_q], read_b[tag_q] and write_sum SHALL equal fire; all other read bits SHALL be 0.
REQ-021 tag SHALL equal tag_q in every cycle.
REQ-022 Round-robin search SHALL pick the first i with elig[i]=1, scanning from a start index upward and wrapping modulo FLUX.
REQ-023 IDLE -> SERVE SHALL occur when en=1 and any elig: tag_q = search(ptr), burst_cnt = 0; otherwise the block SHALL stay in IDLE.
REQ-024 In SERVE with fire and burst_cnt < BURST-1, the block SHALL do burst_cnt++ and hold the grant.
REQ-025 In SERVE with fire and burst_cnt == BURST-1, the grant SHALL end with no bubble.
  - tag_q = search(tag_q+1) using the current-cycle elig, burst_cnt = 0, state stays SERVE.
  - If the search set is empty, state -> IDLE and ptr = tag_q+1.
  - A sole eligible flux SHALL be re-granted to itself.
REQ-026 In SERVE with en=1 and !elig[tag_q] (empty, full or masked), the grant SHALL end with no fire that cycle, then apply the REQ-025 rearbitration.
REQ-027 In SERVE with en=0, the block SHALL not fire, go to IDLE and set ptr = tag_q+1; the remaining burst is forfeited.
REQ-028 All index arithmetic SHALL be modulo FLUX.
REQ-029 burst_cnt SHALL be 8 bits and SHALL never exceed BURST-1.
REQ-030 fire_cnt SHALL increment by 1 on each fire and wrap 0xFFFF -> 0x0000.
REQ-031 flux_mask changes SHALL take effect in the same cycle through elig.

Reset
REQ-032 rst_n=0 SHALL immediately and asynchronously set state=IDLE, tag_q=0, ptr=0, burst_cnt=0 and fire_cnt=0.
REQ-033 During reset, read_a, read_b, write_sum and busy SHALL be 0 and tag SHALL be 0, including when reset is asserted mid-burst.
REQ-034 The first arbitration after reset release SHALL search from flux 0.

Verification (FLUX=2, BURST=4)
REQ-035 Both fluxes always eligible, en=1 from cycle 0:
  - cycle 0: IDLE, no fire.
  - cycles 1-4: tag=0.
  - cycles 5-8: tag=1.
  - cycles 9-12: tag=0.
  - fire_cnt=8 after cycle 8.
REQ-036 Only flux 1 eligible: tag=1 and write_sum=1 in every cycle after the first SERVE cycle, continuously across the burst boundary.
REQ-037 full_sum[0] rises after 2 fires on flux 0, with flux 1 eligible:
  - that cycle: write_sum=0.
  - next cycle: tag=1, fire.
REQ-038 en drops mid-burst on flux 0:
  - same cycle: write_sum=0.
  - next cycle: busy=0.
  - after en=1 again: IDLE cycle, then grant to flux 1.
REQ-039 rst_n asserted between clock edges during SERVE: read/write/busy drop to 0 and fire_cnt reads 0 with no clock edge.
REQ-040 flux_mask=2'b00 with all FIFOs ready: busy=0, no read/write for 20 cycles; fire_cnt stays 0.

Source files
------------

// File: rtl/flux_scheduler_if.sv
// rtl/flux_scheduler_if.sv - handshake bundle between the flux scheduler and its FIFO environment
interface flux_scheduler_if #(
  parameter int FLUX = 2
) ();
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;

  logic                 en;
  logic [FLUX-1:0]      flux_mask;
  logic [FLUX-1:0]      empty_a;
  logic [FLUX-1:0]      empty_b;
  logic [FLUX-1:0]      full_sum;
  logic [FLUX-1:0]      read_a;
  logic [FLUX-1:0]      read_b;
  logic                 write_sum;
  logic [TAG_WIDTH-1:0] tag;
  logic                 busy;
  logic [15:0]          fire_cnt;

  modport master (
    output en, flux_mask, empty_a, empty_b, full_sum,
    input  read_a, read_b, write_sum, tag, busy, fire_cnt
  );

  modport slave (
    input  en, flux_mask, empty_a, empty_b, full_sum,
    output read_a, read_b, write_sum, tag, busy, fire_cnt
  );
endinterface

// File: rtl/flux_scheduler.sv
// rtl/flux_scheduler.sv - round-robin burst scheduler feeding one two-operand actor from FLUX fluxes
module flux_scheduler #(
  parameter int FLUX  = 2,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  flux_scheduler_if.slave    bus
);
  localparam int              TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam logic [7:0]      BURST_LAST = 8'(BURST - 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t               state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic [15:0]          fire_cnt_q, fire_cnt_d;

  logic [FLUX-1:0]      elig;
  logic                 fire;
  logic                 start_found, next_found;
  logic [TAG_WIDTH-1:0] start_idx, next_idx;

  function automatic logic [TAG_WIDTH-1:0] wrap_inc(input logic [TAG_WIDTH-1:0] i);
    return (int'(i) >= FLUX - 1) ? '0 : i + 1'b1;
  endfunction

  // Smallest circular distance from start wins; the MSB of the result flags a hit.
  function automatic logic [TAG_WIDTH:0] search(input logic [TAG_WIDTH-1:0] start,
                                                input logic [FLUX-1:0]      e);
    int                   best_off;
    int                   off;
    logic [TAG_WIDTH-1:0] idx;
    best_off = FLUX;
    idx      = '0;
    for (int i = 0; i < FLUX; i++) begin
      off = (i - int'(start) + FLUX) % FLUX;
      if (e[i] && off < best_off) begin
        best_off = off;
        idx      = TAG_WIDTH'(i);
      end
    end
    return {best_off < FLUX, idx};
  endfunction

  always_comb begin
    elig = bus.flux_mask & ~bus.empty_a & ~bus.empty_b & ~bus.full_sum;
    fire = (state_q == SERVE) & bus.en & elig[tag_q];
  end

  assign bus.read_a    = fire ? (FLUX'(1) << tag_q) : '0;
  assign bus.read_b    = bus.read_a;
  assign bus.write_sum = fire;
  assign bus.tag       = tag_q;
  assign bus.busy      = (state_q == SERVE);
  assign bus.fire_cnt  = fire_cnt_q;

  always_comb begin
    {start_found, start_idx} = search(ptr_q, elig);
    {next_found, next_idx}   = search(wrap_inc(tag_q), elig);

    state_d     = state_q;
    tag_d       = tag_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    fire_cnt_d  = fire ? fire_cnt_q + 16'd1 : fire_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.en && start_found) begin
          state_d     = SERVE;
          tag_d       = start_idx;
          burst_cnt_d = '0;
        end
      end
      SERVE: begin
        if (!bus.en) begin
          state_d     = IDLE;
          ptr_d       = wrap_inc(tag_q);
          burst_cnt_d = '0;
        end else if (fire && burst_cnt_q < BURST_LAST) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end else if (next_found) begin
          // Burst exhausted or current flux stalled: hand over without a bubble.
          tag_d       = next_idx;
          burst_cnt_d = '0;
        end else begin
          state_d     = IDLE;
          ptr_d       = wrap_inc(tag_q);
          burst_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
      fire_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      fire_cnt_q  <= fire_cnt_d;
    end
  end
endmodule

// File: tb/tb_flux_scheduler.sv
// tb/tb_flux_scheduler.sv - randomized and directed bench for flux_scheduler against a behavioural model
module tb_flux_scheduler;
  localparam int FLUX  = 2;
  localparam int BURST = 4;

  logic clk;
  logic rst_n;

  flux_scheduler_if #(.FLUX(FLUX)) bus ();

  flux_scheduler #(.FLUX(FLUX), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: grant holder, remaining budget of the current grant, search start, total fires.
  int m_serving, m_cur, m_left, m_ptr, m_fires;

  logic [31:0] obs_tag, obs_write, obs_busy, obs_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pick(input int start, input logic [FLUX-1:0] e);
    for (int k = 0; k < FLUX; k++) begin
      if (e[(start + k) % FLUX]) return (start + k) % FLUX;
    end
    return -1;
  endfunction

  function automatic logic [FLUX-1:0] rbits(input int pct);
    logic [FLUX-1:0] r;
    for (int i = 0; i < FLUX; i++) r[i] = ($urandom_range(0, 99) < pct);
    return r;
  endfunction

  task automatic model_reset();
    m_serving = 0; m_cur = 0; m_left = 0; m_ptr = 0; m_fires = 0;
  endtask

  // Called just after a rising edge; leaves just after the next rising edge.
  task automatic step(input logic e, input logic [FLUX-1:0] m, input logic [FLUX-1:0] ea,
                      input logic [FLUX-1:0] eb, input logic [FLUX-1:0] fs);
    logic [FLUX-1:0] el;
    logic            f;
    int              n;
    bus.en = e; bus.flux_mask = m; bus.empty_a = ea; bus.empty_b = eb; bus.full_sum = fs;
    el = m & ~ea & ~eb & ~fs;
    f  = (m_serving != 0) && e && el[m_cur];
    @(negedge clk);
    check("read_a",    32'(bus.read_a),    f ? (32'd1 << m_cur) : 32'd0);
    check("read_b",    32'(bus.read_b),    f ? (32'd1 << m_cur) : 32'd0);
    check("write_sum", 32'(bus.write_sum), 32'(f));
    check("tag",       32'(bus.tag),       32'(m_cur));
    check("busy",      32'(bus.busy),      32'(m_serving != 0));
    check("fire_cnt",  32'(bus.fire_cnt),  32'(m_fires & 16'hFFFF));
    obs_tag = 32'(bus.tag); obs_write = 32'(bus.write_sum);
    obs_busy = 32'(bus.busy); obs_cnt = 32'(bus.fire_cnt);
    @(posedge clk);
    if (m_serving == 0) begin
      n = pick(m_ptr, el);
      if (e && n >= 0) begin
        m_serving = 1; m_cur = n; m_left = BURST;
      end
    end else if (!e) begin
      m_serving = 0; m_ptr = (m_cur + 1) % FLUX;
    end else begin
      if (f) begin
        m_fires++; m_left--;
      end
      if (!f || m_left == 0) begin
        n = pick(m_cur + 1, el);
        if (n < 0) begin
          m_serving = 0; m_ptr = (m_cur + 1) % FLUX;
        end else begin
          m_cur = n; m_left = BURST;
        end
      end
    end
    #1;
  endtask

  // Asserts reset between edges, checks outputs with no clock edge, releases after one edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_read_a",    32'(bus.read_a),    32'd0);
    check("rst_read_b",    32'(bus.read_b),    32'd0);
    check("rst_write_sum", 32'(bus.write_sum), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_tag",       32'(bus.tag),       32'd0);
    check("rst_fire_cnt",  32'(bus.fire_cnt),  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int exp_tags[13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.flux_mask = '0; bus.empty_a = '1; bus.empty_b = '1; bus.full_sum = '0;
    model_reset();
    @(posedge clk);
    #1;
    async_reset();

    for (int c = 0; c < 13; c++) begin
      step(1'b1, '1, '0, '0, '0);
      if (c == 0) check("r035_idle_busy", obs_busy, 32'd0);
      else        check("r035_tag", obs_tag, 32'(exp_tags[c]));
      if (c == 9) check("r035_fire_cnt", obs_cnt, 32'd8);
    end

    async_reset();
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 2'b10, '0, '0, '0);
      if (c >= 2) begin
        check("r036_tag", obs_tag, 32'd1);
        check("r036_write", obs_write, 32'd1);
      end
    end

    async_reset();
    for (int c = 0; c < 3; c++) step(1'b1, '1, '0, '0, '0);
    step(1'b1, '1, '0, '0, 2'b01);
    check("r037_stall_write", obs_write, 32'd0);
    step(1'b1, '1, '0, '0, 2'b01);
    check("r037_next_tag", obs_tag, 32'd1);
    check("r037_next_write", obs_write, 32'd1);

    async_reset();
    for (int c = 0; c < 3; c++) step(1'b1, '1, '0, '0, '0);
    step(1'b0, '1, '0, '0, '0);
    check("r038_drop_write", obs_write, 32'd0);
    step(1'b0, '1, '0, '0, '0);
    check("r038_busy_low", obs_busy, 32'd0);
    step(1'b1, '1, '0, '0, '0);
    check("r038_idle_cycle", obs_busy, 32'd0);
    step(1'b1, '1, '0, '0, '0);
    check("r038_regrant_tag", obs_tag, 32'd1);
    check("r038_regrant_write", obs_write, 32'd1);

    async_reset();
    for (int c = 0; c < 3; c++) step(1'b1, '1, '0, '0, '0);
    async_reset();

    for (int c = 0; c < 20; c++) begin
      step(1'b1, '0, '0, '0, '0);
      check("r040_busy", obs_busy, 32'd0);
      check("r040_write", obs_write, 32'd0);
      check("r040_fire_cnt", obs_cnt, 32'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step($urandom_range(0, 9) != 0, rbits(85), rbits(15), rbits(15), rbits(15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
